// File: rtl/dmem_master_if.sv
// dmem_master_if: core request/response and synchronous-RAM signals of dmem_master.
// master = the dmem_master side; slave = the core plus RAM side.
interface dmem_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_we, ram_addr, ram_wdata
    );
    modport slave (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/dmem_master.sv
// dmem_master: byte/half/word loads and read-modify-write sub-word stores on a sync-read RAM.
// Define MISALIGN_TRAP_EN to answer misaligned requests with rsp_err instead of force-aligning them.
module dmem_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           rstn,
    dmem_master_if.master bus
);
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
    state_t            state_q, state_d;
    logic              init_q;
    logic              we_q, we_d, uns_q, uns_d;
    logic [1:0]        size_q, size_d, lane_q, lane_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic              accept, mis;
    logic [4:0]        sh;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_v, merge_v, bmask;
    logic              unused_addr;

    assign unused_addr    = ^bus.req_addr;
    assign bus.req_ready  = init_q && state_q == IDLE;
    assign accept         = bus.req_valid && bus.req_ready;
    assign mis            = bus.req_size[1] ? |bus.req_addr[1:0] : bus.req_size[0] & bus.req_addr[0];
    assign sh             = {lane_q, 3'b000};
    assign byte_v         = 8'(bus.ram_rdata >> sh);
    assign half_v         = lane_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
    assign load_v         = size_q[1] ? bus.ram_rdata :
                            size_q[0] ? {{16{~uns_q & half_v[15]}}, half_v} :
                                        {{24{~uns_q & byte_v[7]}}, byte_v};
    assign bmask          = 32'hFF << sh;
    // Lane bits below the access size are never consulted, which force-aligns misaligned accesses.
    assign merge_v        = size_q[0] ? (lane_q[1] ? {wdata_q, bus.ram_rdata[15:0]} : {bus.ram_rdata[31:16], wdata_q}) :
                                        (bus.ram_rdata & ~bmask) | ({24'd0, wdata_q[7:0]} << sh);
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        uns_d       = uns_q;
        size_d      = size_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: if (accept) begin
                we_d        = bus.req_we;
                uns_d       = bus.req_unsigned;
                size_d      = bus.req_size;
                lane_d      = bus.req_addr[1:0];
                wdata_d     = bus.req_wdata[15:0];
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                if (TRAP && mis) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    ram_addr_d = bus.req_addr[ADDR_W+1:2];
                    state_d    = (bus.req_we && bus.req_size[1]) ? WR : RD;
                    ram_we_d   = bus.req_we && bus.req_size[1];
                    ram_wdata_d = (bus.req_we && bus.req_size[1]) ? bus.req_wdata : ram_wdata_q;
                end
            end
            RD: state_d = CAP;
            CAP: begin
                state_d     = we_q ? WR : RESP;
                ram_we_d    = we_q;
                ram_wdata_d = we_q ? merge_v : ram_wdata_q;
                rsp_valid_d = !we_q;
                rsp_rdata_d = we_q ? '0 : load_v;
            end
            WR: begin
                state_d     = RESP;
                ram_we_d    = 1'b0;
                rsp_valid_d = 1'b1;
            end
            RESP: if (bus.rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            init_q      <= 1'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= 1'b1;
            we_q        <= we_d;
            uns_q       <= uns_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_dmem_master.sv
// tb_dmem_master: table-driven scoreboard bench for dmem_master with a behavioural sync-read RAM.
// Build with MISALIGN_TRAP_EN defined to check the misalignment trap instead of force-alignment.
module tb_dmem_master;
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] wd;
        logic [31:0] rd;
        int          lat;
        logic [31:0] wv;
    } vec_t;
    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          nwr;
        logic [31:0] wv;
        logic [9:0]  wa;
    } exp_t;

    logic        clk;
    logic        rstn = 1'b1;
    logic        clr;
    logic [31:0] mem [1024];
    int          wr_cnt = 0;
    logic [9:0]  last_wa;
    logic [31:0] last_wd;
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sbq[$];
    vec_t        vecs[22];

    dmem_master_if #(.ADDR_W(10), .DATA_W(32)) bus ();
    dmem_master #(.ADDR_W(10), .DATA_W(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else begin
            if (bus.ram_we) begin
                mem[bus.ram_addr] <= bus.ram_wdata;
                wr_cnt  <= wr_cnt + 1;
                last_wa <= bus.ram_addr;
                last_wd <= bus.ram_wdata;
            end
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [1:0] size, input bit uns,
                          input logic [31:0] wd, input logic [31:0] rd, input bit err, input int lat,
                          input int nwr, input logic [31:0] wv, input int hold);
        exp_t        e;
        int          k;
        int          w0;
        logic [31:0] held;
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_addr = addr;
        bus.req_size = size;
        bus.req_unsigned = uns;
        bus.req_wdata = wd;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        w0 = wr_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_we = ~we;
        bus.req_addr = ~addr;
        bus.req_size = ~size;
        bus.req_unsigned = ~uns;
        bus.req_wdata = ~wd;
        sbq.push_back('{rd, err, lat, nwr, wv, addr[11:2]});
        k = 1;
        while (!bus.rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        e = sbq.pop_front();
        chk("latency", 32'(k), 32'(e.lat));
        chk("rsp_rdata", bus.rsp_rdata, e.rd);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        held = bus.rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_rdata", bus.rsp_rdata, held);
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        chk("wr_count", 32'(wr_cnt - w0), 32'(e.nwr));
        if (e.nwr > 0) begin
            chk("wr_addr", 32'(last_wa), 32'(e.wa));
            chk("wr_data", last_wd, e.wv);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int          k;
        int          w0;
        vecs = '{
            '{1'b1, 32'h0000_00DC, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 2, 32'hDEAD_BEEF},
            '{1'b0, 32'h0000_00DC, 2'd2, 1'b0, 32'h0,         32'hDEAD_BEEF, 3, 32'h0},
            '{1'b1, 32'h0000_00DD, 2'd0, 1'b0, 32'hFFFF_FF11, 32'h0000_0000, 4, 32'hDEAD_11EF},
            '{1'b0, 32'h0000_00DC, 2'd2, 1'b0, 32'h0,         32'hDEAD_11EF, 3, 32'h0},
            '{1'b0, 32'h0000_00DD, 2'd0, 1'b1, 32'h0,         32'h0000_0011, 3, 32'h0},
            '{1'b0, 32'h0000_00DF, 2'd0, 1'b0, 32'h0,         32'hFFFF_FFDE, 3, 32'h0},
            '{1'b0, 32'h0000_00DC, 2'd0, 1'b0, 32'h0,         32'hFFFF_FFEF, 3, 32'h0},
            '{1'b0, 32'h0000_00DE, 2'd1, 1'b0, 32'h0,         32'hFFFF_DEAD, 3, 32'h0},
            '{1'b0, 32'h0000_00DE, 2'd1, 1'b1, 32'h0,         32'h0000_DEAD, 3, 32'h0},
            '{1'b0, 32'h0000_00DC, 2'd1, 1'b0, 32'h0,         32'h0000_11EF, 3, 32'h0},
            '{1'b1, 32'h0000_00DE, 2'd1, 1'b0, 32'h1234_BEEF, 32'h0000_0000, 4, 32'hBEEF_11EF},
            '{1'b0, 32'h0000_00DC, 2'd3, 1'b0, 32'h0,         32'hBEEF_11EF, 3, 32'h0},
            '{1'b1, 32'h1000_00DC, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0000_0000, 2, 32'hCAFE_F00D},
            '{1'b0, 32'h0000_00DC, 2'd2, 1'b0, 32'h0,         32'hCAFE_F00D, 3, 32'h0},
            '{1'b1, 32'h0000_0000, 2'd0, 1'b0, 32'h0000_00AB, 32'h0000_0000, 4, 32'h0000_00AB},
            '{1'b1, 32'h0000_0003, 2'd0, 1'b0, 32'h0000_00FF, 32'h0000_0000, 4, 32'hFF00_00AB},
            '{1'b0, 32'h0000_0003, 2'd0, 1'b0, 32'h0,         32'hFFFF_FFFF, 3, 32'h0},
            '{1'b0, 32'h0000_0003, 2'd0, 1'b1, 32'h0,         32'h0000_00FF, 3, 32'h0},
            '{1'b0, 32'h0000_0002, 2'd1, 1'b0, 32'h0,         32'hFFFF_FF00, 3, 32'h0},
            '{1'b1, 32'h0000_0FFC, 2'd2, 1'b0, 32'h0102_0304, 32'h0000_0000, 2, 32'h0102_0304},
            '{1'b0, 32'hFFFF_FFFC, 2'd2, 1'b0, 32'h0,         32'h0102_0304, 3, 32'h0},
            '{1'b0, 32'h0000_0FFD, 2'd0, 1'b1, 32'h0,         32'h0000_0003, 3, 32'h0}
        };
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_size = '0;
        bus.req_unsigned = 1'b0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        clr = 1'b1;
        #2 rstn = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
        rstn = 1'b1;
        clr = 1'b0;
        chk("rel_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("post_rel_req_ready", 32'(bus.req_ready), 32'd1);

        foreach (vecs[i])
            do_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wd,
                   vecs[i].rd, 1'b0, vecs[i].lat, vecs[i].we ? 1 : 0, vecs[i].wv, 0);

        do_req(1'b0, 32'h0000_00DC, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 3, 0, 32'h0, 5);

        // Reset in the middle of the WR cycle of a word store to word 147.
        do_req(1'b1, 32'h0000_024C, 2'd2, 1'b0, 32'h5555_AAAA, 32'h0, 1'b0, 2, 1, 32'h5555_AAAA, 0);
        w0 = wr_cnt;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_addr = 32'h0000_024C;
        bus.req_size = 2'd2;
        bus.req_wdata = 32'h1234_5678;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("wr_state_ram_we", 32'(bus.ram_we), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("midrst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("midrst_ram_wdata", bus.ram_wdata, 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        chk("midrst_rel_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("midrst_ready_back", 32'(bus.req_ready), 32'd1);
        chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_no_write", 32'(wr_cnt - w0), 32'd0);
        do_req(1'b0, 32'h0000_024C, 2'd2, 1'b0, 32'h0, 32'h5555_AAAA, 1'b0, 3, 0, 32'h0, 0);

        do_req(1'b1, 32'h0000_0124, 2'd2, 1'b0, 32'h8765_4321, 32'h0, 1'b0, 2, 1, 32'h8765_4321, 0);
`ifdef MISALIGN_TRAP_EN
        do_req(1'b0, 32'h0000_0125, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0);
        do_req(1'b0, 32'h0000_0126, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0);
        do_req(1'b1, 32'h0000_0127, 2'd1, 1'b0, 32'h0000_FFFF, 32'h0, 1'b1, 1, 0, 32'h0, 0);
        do_req(1'b0, 32'h0000_0124, 2'd2, 1'b0, 32'h0, 32'h8765_4321, 1'b0, 3, 0, 32'h0, 0);
`else
        do_req(1'b0, 32'h0000_0125, 2'd1, 1'b0, 32'h0, 32'h0000_4321, 1'b0, 3, 0, 32'h0, 0);
        do_req(1'b0, 32'h0000_0126, 2'd2, 1'b0, 32'h0, 32'h8765_4321, 1'b0, 3, 0, 32'h0, 0);
        do_req(1'b1, 32'h0000_0127, 2'd1, 1'b0, 32'h0000_FFFF, 32'h0, 1'b0, 4, 1, 32'hFFFF_4321, 0);
        do_req(1'b0, 32'h0000_0124, 2'd2, 1'b0, 32'h0, 32'hFFFF_4321, 1'b0, 3, 0, 32'h0, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
